synapse_row_fetcher: RTL

- Read-side sequencer placed directly in front of the single-port off-chip weight RAM (64-bit words, registered-address read).
- On a row request (one presynaptic axon index), issues NUM_COLS consecutive read addresses starting at RowIndex*NUM_COLS.
- Absorbs the RAM's one-cycle read latency and streams the returned weights to the neuron-update stage over a valid/ready handshake with full backpressure.
- Never writes the RAM.

---
 rtl/synapse_row_fetcher.sv | 138 +++++++++++++
 1 files changed

// File: rtl/synapse_row_fetcher.sv
// Read-side sequencer for the off-chip weight RAM: fetches one axon row of
// NUM_COLS words and streams it downstream over valid/ready with backpressure.
module synapse_row_fetcher #(
  parameter int WORD_WIDTH = 64,
  parameter int ADDR_WIDTH = 25,
  parameter int NUM_ROWS   = 1024,
  parameter int NUM_COLS   = 256,
  parameter int ROW_WIDTH  = 10,
  parameter int COL_WIDTH  = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  RowRequest,
  input  logic [ROW_WIDTH-1:0]  RowIndex,
  output logic                  RowAccept,
  output logic                  RowDone,
  output logic                  RowError,
  output logic                  RamChipEnable,
  output logic                  RamWriteEnable,
  output logic [ADDR_WIDTH-1:0] RamAddress,
  input  logic [WORD_WIDTH-1:0] RamData,
  output logic                  WeightValid,
  output logic [WORD_WIDTH-1:0] WeightData,
  output logic [COL_WIDTH-1:0]  WeightColumn,
  output logic                  WeightLast,
  input  logic                  WeightReady,
  output logic                  Busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [ROW_WIDTH:0]    ROW_LIMIT = (ROW_WIDTH + 1)'(NUM_ROWS);
  localparam logic [ADDR_WIDTH-1:0] COLS_A    = ADDR_WIDTH'(NUM_COLS);
  localparam logic [COL_WIDTH-1:0]  LAST_COL  = COL_WIDTH'(NUM_COLS - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] base;
  logic [COL_WIDTH-1:0]  col;

  logic                  vld_p1;
  logic [COL_WIDTH-1:0]  col_p1;
  logic                  last_p1;

  logic [WORD_WIDTH-1:0] fifo_data [2];
  logic [COL_WIDTH-1:0]  fifo_col  [2];
  logic                  fifo_last [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;

  logic                  pop;
  logic                  issue;
  logic [2:0]            pending;

  assign pop     = WeightValid & WeightReady;
  // FIFO words plus the word still in the RAM must leave room after this cycle's pop
  assign pending = {1'b0, count} + {2'b00, vld_p1};
  assign issue   = (state == ISSUE) && (pending < (3'd2 + {2'b00, pop}));

  assign RamChipEnable  = issue & ~Reset;
  assign RamWriteEnable = 1'b0;
  assign RamAddress     = base + ADDR_WIDTH'(col);

  assign RowAccept    = (state == IDLE);
  assign Busy         = (state != IDLE);
  assign WeightValid  = (count != 2'd0);
  assign WeightData   = WeightValid ? fifo_data[rd_ptr] : '0;
  assign WeightColumn = WeightValid ? fifo_col[rd_ptr]  : '0;
  assign WeightLast   = WeightValid & fifo_last[rd_ptr];

  // p0 -> p1: tag the issued address with its column while the RAM reads
  // p1 -> p2: RAM word lands in the output FIFO
  always_ff @(posedge Clock) begin
    if (issue) begin
      col_p1  <= col;
      last_p1 <= (col == LAST_COL);
    end
    if (vld_p1) begin
      fifo_data[wr_ptr] <= RamData;
      fifo_col[wr_ptr]  <= col_p1;
      fifo_last[wr_ptr] <= last_p1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      base     <= '0;
      col      <= '0;
      vld_p1   <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      RowDone  <= 1'b0;
      RowError <= 1'b0;
    end else begin
      RowDone  <= 1'b0;
      RowError <= 1'b0;
      vld_p1   <= issue;

      if (vld_p1) wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
      unique case ({vld_p1, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      unique case (state)
        IDLE: begin
          if (RowRequest) begin
            if ({1'b0, RowIndex} >= ROW_LIMIT) begin
              RowError <= 1'b1;
            end else begin
              base  <= ADDR_WIDTH'(RowIndex) * COLS_A;
              col   <= '0;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            col <= col + COL_WIDTH'(1);
            if (col == LAST_COL) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && WeightLast) begin
            RowDone <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
